// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the MIPS datapath and word-addressed data memory.
// Word-granular reads/writes, sub-word RMW for SB/SH, LWL/LWR merge, alignment checks.
module mips_cpu_lsu #(
  parameter int WORD_BITS          = 32,
  parameter bit ERR_ON_UNSUPPORTED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [3:0]           op,
  input  logic [31:0]          addr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_BITS-1:0] rt_old,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 err,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_BITS-1:0] mem_writedata,
  input  logic [WORD_BITS-1:0] mem_readdata
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LWL = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_LWR = 4'b0110;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state, state_next;
  logic [3:0]             op_q;
  logic [31:0]            addr_q;
  logic [WORD_BITS-1:0]   rt_q;
  logic [WORD_BITS-1:0]   wbuf;
  logic                   err_q;

  logic                   in_supported;
  logic                   in_misaligned;
  logic                   acc_err;
  logic                   accept;

  logic [4:0]             sh_k;
  logic [4:0]             sh_inv;
  logic [WORD_BITS-1:0]   byte_src;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;
  logic [WORD_BITS-1:0]   load_fmt;
  logic [WORD_BITS-1:0]   merge_mask;
  logic [WORD_BITS-1:0]   merge_data;
  logic [WORD_BITS-1:0]   merged;

  // Handshake: a request is taken on a rising edge where req=1 and busy=0; it is
  // answered by exactly one done pulse, and req seen while busy=1 is ignored.
  assign accept = (state == IDLE) && req;

  always_comb begin
    in_supported  = 1'b1;
    in_misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: in_misaligned = 1'b0;
      OP_LH, OP_LHU, OP_SH:                 in_misaligned = addr[0];
      OP_LW, OP_SW:                         in_misaligned = |addr[1:0];
      default:                              in_supported  = 1'b0;
    endcase
    acc_err = in_misaligned || (!in_supported && ERR_ON_UNSUPPORTED);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (in_misaligned || !in_supported) state_next = RESP;
          else if (op == OP_SW)               state_next = WRITE;
          else                                state_next = READ;
        end
      end
      READ:    state_next = op_q[3] ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Big-endian: byte offset k lives at bits 31-8k, so right-shift by 8*(3-k).
  always_comb begin
    sh_k     = {addr_q[1:0], 3'b000};
    sh_inv   = {~addr_q[1:0], 3'b000};
    byte_src = mem_readdata >> sh_inv;
    byte_v   = byte_src[7:0];
    half_v   = addr_q[1] ? mem_readdata[15:0] : mem_readdata[31:16];
    case (op_q[2:0])
      3'b000:  load_fmt = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
      3'b010:  load_fmt = (mem_readdata << sh_k) | (rt_q & ((32'h1 << sh_k) - 32'h1));
      3'b100:  load_fmt = {24'h0, byte_v};
      3'b101:  load_fmt = {16'h0, half_v};
      3'b110:  load_fmt = (mem_readdata >> sh_inv) | (rt_q & ~(32'hFFFF_FFFF >> sh_inv));
      default: load_fmt = mem_readdata;
    endcase
    // wbuf still holds the latched store data while in READ.
    if (op_q[0]) begin
      merge_mask = addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      merge_data = {2{wbuf[15:0]}};
    end else begin
      merge_mask = 32'hFF00_0000 >> sh_k;
      merge_data = {4{wbuf[7:0]}};
    end
    merged = (mem_readdata & ~merge_mask) | (merge_data & merge_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 4'h0;
      addr_q <= 32'h0;
      rt_q   <= '0;
      wbuf   <= '0;
      err_q  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        addr_q <= addr;
        rt_q   <= rt_old;
        wbuf   <= wdata;
        err_q  <= acc_err;
      end
      if (state == READ) begin
        if (op_q[3]) wbuf  <= merged;
        else         rdata <= load_fmt;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == RESP);
  assign err           = (state == RESP) && err_q;
  assign mem_read      = (state == READ);
  assign mem_write     = (state == WRITE);
  assign mem_writedata = (state == WRITE) ? wbuf : '0;
  assign mem_address   = {2'b00, addr_q[31:2]};

endmodule
